// File: rtl/larpix_uart_link.sv
// rtl/larpix_uart_link.sv - full-duplex serial word link: TX serializer and RX deserializer with odd-parity check
module larpix_uart_link #(
  parameter int WIDTH        = 64,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_tx_data,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_out,
  output logic             tx_busy,
  input  logic             rx_in,
  input  logic             uld_rx_data,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_empty,
  output logic             parity_error
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           tx_state, tx_next;
  logic [CW-1:0]    tx_cnt;
  logic [BW-1:0]    tx_bit;
  logic [WIDTH-1:0] tx_shift;
  logic             tx_bit_end, tx_line;

  assign tx_bit_end = (tx_cnt == BIT_END);

  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE:  if (ld_tx_data) tx_next = S_START;
      S_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_bit == LAST_BIT) tx_next = S_STOP;
      end
      S_STOP:  if (tx_bit_end) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // Line and busy are registered off the state, so both lag the load by one edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_out   <= tx_line;
      tx_busy  <= (tx_state != S_IDLE);
      if (tx_state == S_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (ld_tx_data) tx_shift <= tx_data;
      end else begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
        if (tx_state == S_DATA && tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 1'b1;
        end
      end
    end
  end

  state_t           rx_state, rx_next;
  logic             rx_s1, rx_s2, rx_arm;
  logic [CW-1:0]    rx_cnt;
  logic [BW-1:0]    rx_bit;
  logic [WIDTH-1:0] rx_frame;
  logic             rx_sample, rx_commit;

  assign rx_sample = (rx_state == S_START) ? (rx_cnt == MID_BIT) : (rx_cnt == BIT_END);

  always_comb begin
    rx_next   = rx_state;
    rx_commit = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_arm && !rx_s2) rx_next = S_START;
      S_START: if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && rx_bit == LAST_BIT) rx_next = S_STOP;
      S_STOP: begin
        if (rx_sample) begin
          rx_next   = S_IDLE;
          rx_commit = rx_s2;
        end
      end
      default: rx_next = S_IDLE;
    endcase
  end

  // rx_arm blocks a new start after a framing error until the line has been seen high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_arm       <= 1'b0;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_frame     <= '0;
      rx_data      <= '0;
      parity_error <= 1'b0;
      rx_empty     <= 1'b1;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      if (rx_state == S_IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
        if (rx_s2) rx_arm <= 1'b1;
      end else begin
        rx_cnt <= rx_sample ? '0 : rx_cnt + 1'b1;
        if (rx_state == S_DATA && rx_sample) begin
          rx_frame <= {rx_s2, rx_frame[WIDTH-1:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
        if (rx_state == S_STOP && rx_sample && !rx_s2) rx_arm <= 1'b0;
      end
      if (rx_commit) begin
        rx_data      <= rx_frame[WIDTH-2:0];
        parity_error <= ~^rx_frame;
        rx_empty     <= 1'b0;
      end else if (uld_rx_data) begin
        rx_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_larpix_uart_link.sv
// tb/tb_larpix_uart_link.sv - directed loopback and line-injection bench for larpix_uart_link
module tb_larpix_uart_link;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_tx_data = 1'b0;
  logic        uld_rx_data = 1'b0;
  logic        loop_en = 1'b1;
  logic        rx_drv = 1'b1;
  logic [63:0] tx_data = '0;
  logic        tx_out, tx_busy, rx_empty, parity_error;
  logic [62:0] rx_data;
  wire         rx_in;
  int          nvec = 0;
  int          nmis = 0;
  int          busy_cnt;

  assign rx_in = loop_en ? tx_out : rx_drv;

  always #5 clk = ~clk;

  larpix_uart_link #(.WIDTH(64), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
    .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in), .uld_rx_data(uld_rx_data),
    .rx_data(rx_data), .rx_empty(rx_empty), .parity_error(parity_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] w);
    tx_data    = w;
    ld_tx_data = 1'b1;
    tick(1);
    ld_tx_data = 1'b0;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    tick(1);
    uld_rx_data = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    tick(1);
    for (int i = 0; i < 400 && tx_busy; i++) tick(1);
    check(tag, tx_busy, 0);
  endtask

  task automatic wait_rx(input string tag);
    for (int i = 0; i < 600 && rx_empty; i++) tick(1);
    check(tag, rx_empty, 0);
  endtask

  task automatic rx_frame(input logic [63:0] w, input logic stop);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 64; i++) begin
      rx_drv = w[i];
      tick(CPB);
    end
    rx_drv = stop;
    tick(CPB);
    rx_drv = 1'b1;
    tick(CPB);
  endtask

  initial begin
    tick(2);
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_parity", parity_error, 0);
    reset_n = 1'b1;
    tick(2);

    load(64'h1);
    wait_rx("good_wait");
    check("good_data", rx_data, 63'h1);
    check("good_parity", parity_error, 0);
    unload();
    check("good_unload_empty", rx_empty, 1);
    check("good_unload_hold", rx_data, 63'h1);
    wait_idle("good_idle");

    load(64'h3);
    wait_rx("badpar_wait");
    check("badpar_data", rx_data, 63'h3);
    check("badpar_parity", parity_error, 1);
    unload();
    wait_idle("badpar_idle");

    load(64'h7);
    check("tx_latency_busy0", tx_busy, 0);
    tick(1);
    check("tx_start_bit", tx_out, 0);
    check("tx_start_busy", tx_busy, 1);
    busy_cnt = 0;
    for (int i = 0; i < 400 && tx_busy; i++) begin
      busy_cnt++;
      if (i == 50) begin
        tx_data    = 64'hF;
        ld_tx_data = 1'b1;
      end else begin
        ld_tx_data = 1'b0;
      end
      tick(1);
    end
    ld_tx_data = 1'b0;
    check("busy_cycles", busy_cnt, 264);
    wait_rx("busy_wait");
    check("busy_data", rx_data, 63'h7);
    check("busy_parity", parity_error, 0);
    tick(300);
    check("busy_no_second_tx", tx_busy, 0);
    check("busy_no_second_rx", rx_data, 63'h7);

    load(64'h21);
    wait_idle("b2b_first_idle");
    load(64'h8000_0000_0000_0042);
    tick(10);
    check("b2b_first_data", rx_data, 63'h21);
    check("b2b_first_parity", parity_error, 1);
    wait_idle("b2b_second_idle");
    tick(20);
    check("overrun_data", rx_data, 63'h42);
    check("overrun_parity", parity_error, 0);
    check("overrun_empty", rx_empty, 0);
    unload();
    check("overrun_unload", rx_empty, 1);

    loop_en = 1'b0;
    tick(5);
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(100);
    check("glitch_empty", rx_empty, 1);
    check("glitch_data", rx_data, 63'h42);

    rx_frame(64'h55, 1'b1);
    wait_rx("inj_wait");
    check("inj_data", rx_data, 63'h55);
    check("inj_parity", parity_error, 1);
    unload();
    rx_frame(64'h1234, 1'b0);
    tick(20);
    check("frame_err_empty", rx_empty, 1);
    check("frame_err_data", rx_data, 63'h55);
    check("frame_err_parity", parity_error, 1);
    tick(10);
    rx_frame(64'h8000_0000_0000_0300, 1'b1);
    wait_rx("rearm_wait");
    check("rearm_data", rx_data, 63'h300);
    check("rearm_parity", parity_error, 0);
    unload();

    loop_en = 1'b1;
    tick(5);
    load(64'hFFFF);
    tick(40);
    reset_n = 1'b0;
    tick(1);
    check("midrst_tx_out", tx_out, 1);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_rx_empty", rx_empty, 1);
    check("midrst_rx_data", rx_data, 0);
    reset_n = 1'b1;
    tick(300);
    check("midrst_no_word", rx_empty, 1);
    check("midrst_tx_idle", tx_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
